queue_arbiter: RTL and testbench

Round-robin output stage that sits directly downstream of N input queues in a router port. Each cycle it selects one non-empty queue head, pops it by pulsing that queue's shift signal, and registers the packet into a one-entry output buffer with a valid/ready handshake toward the link or crossbar. An all-zero packet is the idle/empty code, matching the queue's cleared output, so a request is any non-zero head.

---
 rtl/queue_arbiter_if.sv | 33 +++
 rtl/queue_arbiter.sv | 98 +++++++++
 tb/tb_queue_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/queue_arbiter_if.sv
// queue_arbiter_if: queue heads, pop strobes and output handshake.
// master = arbiter side, slave = queues/downstream side.
interface queue_arbiter_if #(
  parameter int PL = 8,
  parameter int N  = 4
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N*PL-1:0] queue_data;
  logic [N-1:0]    shift_signal;
  logic [PL-1:0]   out_data;
  logic [SW-1:0]   out_src;
  logic            out_valid;
  logic            out_ready;

  modport master (
    input  queue_data,
    input  out_ready,
    output shift_signal,
    output out_data,
    output out_src,
    output out_valid
  );

  modport slave (
    output queue_data,
    output out_ready,
    input  shift_signal,
    input  out_data,
    input  out_src,
    input  out_valid
  );
endinterface

// File: rtl/queue_arbiter.sv
// queue_arbiter: round-robin pop of N queue heads into a 1-entry
// registered output buffer. Ports: clk, rst_n (sync, low), bus (master).
module queue_arbiter #(
  parameter int PL = 8,
  parameter int N  = 4
) (
  input logic             clk,
  input logic             rst_n,
  queue_arbiter_if.master bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic          any_req;
  logic          load;
  logic          fire;
  logic [SW-1:0] grant;
  logic [SW-1:0] grant_nxt;
  logic [N-1:0]  shift;

  logic [PL-1:0] out_data_q, out_data_d;
  logic [SW-1:0] out_src_q, out_src_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    req = '0;
    for (int i = 0; i < N; i++) begin
      req[i] = |bus.queue_data[i*PL +: PL];
    end
  end

  assign any_req = |req;
  assign load    = !out_valid_q || bus.out_ready;
  // Gated by rst_n so a held-in-reset arbiter never pops a queue.
  assign fire    = rst_n && load && any_req;

  // Search rr_ptr, rr_ptr+1, ... wrapping; first requester wins.
  always_comb begin
    int  idx;
    logic found;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr_q) + k) % N;
      if (!found && req[idx]) begin
        grant = SW'(idx);
        found = 1'b1;
      end
    end
  end

  assign grant_nxt = (grant == SW'(N-1))
                   ? '0 : grant + SW'(1);

  always_comb begin
    shift = '0;
    if (fire) shift[grant] = 1'b1;
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      if (any_req) begin
        out_data_d  = bus.queue_data[grant*PL +: PL];
        out_src_d   = grant;
        out_valid_d = 1'b1;
        rr_ptr_d    = grant_nxt;
      end else begin
        out_data_d  = '0;
        out_src_d   = '0;
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.shift_signal = shift;
  assign bus.out_data     = out_data_q;
  assign bus.out_src      = out_src_q;
  assign bus.out_valid    = out_valid_q;
endmodule

// File: tb/tb_queue_arbiter.sv
// tb_queue_arbiter: FIFO-backed queue model plus scoreboard of
// expected captures for queue_arbiter.
module tb_queue_arbiter;
  logic clk;
  logic rst_n;

  queue_arbiter_if #(.PL(8), .N(4)) bus ();

  queue_arbiter #(.PL(8), .N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] src;
    logic [7:0] data;
  } exp_t;

  typedef enum int {K_LOAD, K_IDLE, K_STALL, K_RST} kind_t;

  logic [7:0] fifo [4][$];
  exp_t       sb [$];
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         m_valid = 1'b0;
  int         m_rr    = 0;
  logic [7:0] hold_d  = 8'h00;
  logic [1:0] hold_s  = 2'd0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < 4; i++) fifo[i].delete();
  endtask

  task automatic fill(input int q, input logic [7:0] v,
                      input int n);
    for (int j = 0; j < n; j++) fifo[q].push_back(v);
  endtask

  task automatic step(input string tag);
    logic [3:0] exp_shift;
    kind_t      kind;
    exp_t       e;
    bit         ld;
    int         g;
    int         idx;
    for (int i = 0; i < 4; i++) begin
      bus.queue_data[i*8 +: 8] =
        (fifo[i].size() > 0) ? fifo[i][0] : 8'h00;
    end
    #1;
    exp_shift = 4'b0000;
    kind      = K_STALL;
    if (!rst_n) begin
      kind    = K_RST;
      m_valid = 1'b0;
      m_rr    = 0;
    end else begin
      ld = !m_valid || bus.out_ready;
      g  = -1;
      for (int k = 0; k < 4; k++) begin
        idx = (m_rr + k) % 4;
        if (g < 0 && fifo[idx].size() > 0
            && fifo[idx][0] != 8'h00) g = idx;
      end
      if (ld && g >= 0) begin
        exp_shift[g] = 1'b1;
        e.src  = 2'(g);
        e.data = fifo[g][0];
        sb.push_back(e);
        void'(fifo[g].pop_front());
        m_rr    = (g + 1) % 4;
        m_valid = 1'b1;
        kind    = K_LOAD;
      end else if (ld) begin
        m_valid = 1'b0;
        kind    = K_IDLE;
      end
    end
    check({tag, ".shift"}, 32'(bus.shift_signal),
          32'(exp_shift));
    @(posedge clk);
    #1;
    case (kind)
      K_LOAD: begin
        if (sb.size() == 0) begin
          check({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
          check({tag, ".data"}, 32'(bus.out_data),
                32'(e.data));
          check({tag, ".src"}, 32'(bus.out_src),
                32'(e.src));
          hold_d = e.data;
          hold_s = e.src;
        end
      end
      K_STALL: begin
        check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, ".hold_data"}, 32'(bus.out_data),
              32'(hold_d));
        check({tag, ".hold_src"}, 32'(bus.out_src),
              32'(hold_s));
      end
      default: begin
        check({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".data"}, 32'(bus.out_data), 32'd0);
        check({tag, ".src"}, 32'(bus.out_src), 32'd0);
      end
    endcase
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.out_ready  = 1'b1;
    bus.queue_data = '0;
    @(posedge clk);
    #1;

    // reset hold, then first grant on release
    clear_fifos();
    fill(0, 8'h81, 1);
    for (int c = 0; c < 3; c++) step("rst_hold");
    rst_n = 1'b1;
    step("rst_release");

    // fairness 0,1,2,3,0,1 then grant 2 (0x82)
    rst_n = 1'b0;
    step("rst2");
    rst_n = 1'b1;
    clear_fifos();
    for (int i = 0; i < 4; i++) fill(i, 8'(8'h80 + i), 3);
    for (int c = 0; c < 7; c++) step("fair");

    // backpressure on 0x82, then grant 3
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) step("stall");
    check("stall_out_data", 32'(bus.out_data), 32'h82);
    bus.out_ready = 1'b1;
    step("bp_release");
    check("bp_grant3", 32'(bus.out_src), 32'd3);

    // wrap-around: get rr to 3, lone q2 then lone q0
    clear_fifos();
    fill(2, 8'h83, 1);
    step("wrap_setup");
    fill(2, 8'h85, 1);
    step("wrap_q2");
    check("wrap_src2", 32'(bus.out_src), 32'd2);
    fill(0, 8'h86, 1);
    step("wrap_q0");
    check("wrap_src0", 32'(bus.out_src), 32'd0);

    // drain single packet to idle
    fill(1, 8'h84, 1);
    step("drain_load");
    step("drain_idle");
    step("drain_idle2");

    // reset mid-operation with rr=2 and a stalled buffer
    fill(1, 8'h87, 1);
    step("mid_load");
    bus.out_ready = 1'b0;
    fill(3, 8'h93, 1);
    step("mid_stall");
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) fill(i, 8'(8'hA0 + i), 2);
    step("mid_rst");
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    step("mid_first");
    check("mid_grant0", 32'(bus.out_src), 32'd0);
    for (int c = 0; c < 3; c++) step("mid_rr");

    // random traffic and backpressure
    for (int c = 0; c < 60; c++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0)
        fifo[$urandom_range(0, 3)].push_back(
          8'($urandom_range(1, 255)));
      step("rand");
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 30; c++) step("flush");

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule
